variable_length_encoder: RTL and testbench

Bit packer for the encode side of the variable-length code path. Accepts one code per cycle (`d`, `len` valid bits), appends it LSB-first to a bit buffer, and emits fixed `WIDTH_OUT`-bit words under a valid/ready handshake. A flush request pads the final partial word with zeros, drains it and signals completion. The bit order matches the variable-length decoder, so a packed stream decodes back directly.

---
 rtl/variable_length_encoder_if.sv | 38 +++
 rtl/variable_length_encoder.sv | 129 ++++++++++++
 tb/tb_variable_length_encoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/variable_length_encoder_if.sv
// rtl/variable_length_encoder_if.sv - code-in / word-out bundle for the variable-length bit packer
//
// Signals (directions as seen by the packer, modport slave):
//   push, d, len, flush   in   code stream and flush request from the producer
//   full, size            out  back-pressure and current fill count in bits
//   q, q_valid, q_ready   out/out/in  packed word stream with valid/ready handshake
//   flush_done            out  one-cycle pulse when a flush has drained
// The producer/consumer side uses modport master.

interface variable_length_encoder_if #(
    parameter int WIDTH_IN     = 8,
    parameter int WIDTH_OUT    = 8,
    parameter int BUFFER_WIDTH = 16
);
    localparam int LEN_W  = $clog2(WIDTH_IN) + 1;
    localparam int SIZE_W = $clog2(BUFFER_WIDTH) + 1;

    logic                 push;
    logic [WIDTH_IN-1:0]  d;
    logic [LEN_W-1:0]     len;
    logic                 flush;
    logic                 full;
    logic [SIZE_W-1:0]    size;
    logic [WIDTH_OUT-1:0] q;
    logic                 q_valid;
    logic                 q_ready;
    logic                 flush_done;

    modport master (
        output push, d, len, flush, q_ready,
        input  full, size, q, q_valid, flush_done
    );

    modport slave (
        input  push, d, len, flush, q_ready,
        output full, size, q, q_valid, flush_done
    );
endinterface

// File: rtl/variable_length_encoder.sv
// rtl/variable_length_encoder.sv - LSB-first bit packer from variable-length codes to fixed-width words
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  variable_length_encoder_if.slave: push/d/len/flush in, full/size out,
//        q/q_valid/q_ready word stream, flush_done pulse
// Codes are appended at bit position fill of the buffer; the low WIDTH_OUT
// bits of the buffer are the presented word. All outputs come from registers.

module variable_length_encoder #(
    parameter int WIDTH_IN     = 8,
    parameter int WIDTH_OUT    = 8,
    parameter int BUFFER_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    variable_length_encoder_if.slave    bus
);
    localparam int SIZE_W = $clog2(BUFFER_WIDTH) + 1;

    localparam logic [SIZE_W-1:0]   WO_S    = SIZE_W'(WIDTH_OUT);
    localparam logic [SIZE_W-1:0]   FULL_TH = SIZE_W'(BUFFER_WIDTH - WIDTH_IN);
    localparam logic [WIDTH_IN-1:0] ONES    = '1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BUFFER_WIDTH-1:0] buffer_q, buffer_d;
    logic [SIZE_W-1:0]       fill_q, fill_d;

    logic                    full_w;
    logic                    q_valid_w;
    logic                    pop;
    logic                    acc;
    logic [WIDTH_IN-1:0]     d_masked;
    logic [BUFFER_WIDTH-1:0] buf_pop;
    logic [BUFFER_WIDTH-1:0] buf_push;
    logic [SIZE_W-1:0]       fill_pop;
    logic [SIZE_W-1:0]       fill_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            buffer_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            fill_q   <= fill_d;
        end
    end

    // Status outputs depend on registered state only.
    always_comb begin
        full_w    = (fill_q > FULL_TH) || (state_q != ST_RUN);
        q_valid_w = 1'b0;
        case (state_q)
            ST_RUN:   q_valid_w = (fill_q >= WO_S);
            ST_FLUSH: q_valid_w = (fill_q != '0);
            default:  q_valid_w = 1'b0;
        endcase
    end

    assign bus.full       = full_w;
    assign bus.q_valid    = q_valid_w;
    assign bus.q          = buffer_q[WIDTH_OUT-1:0];
    assign bus.size       = fill_q;
    assign bus.flush_done = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        buffer_d  = buffer_q;
        fill_d    = fill_q;

        pop       = q_valid_w & bus.q_ready;
        acc       = bus.push & ~full_w;

        // Shifting all-ones by len leaves exactly len low ones; len == WIDTH_IN keeps every bit.
        d_masked  = bus.d & ~(ONES << bus.len);

        // Pop first: in FLUSH the final partial word may hold fewer than WIDTH_OUT bits.
        buf_pop   = pop ? (buffer_q >> WIDTH_OUT) : buffer_q;
        fill_pop  = fill_q;
        if (pop) begin
            fill_pop = (fill_q > WO_S) ? (fill_q - WO_S) : '0;
        end

        // Then push at the post-pop fill position.
        buf_push  = buf_pop;
        fill_push = fill_pop;
        if (acc) begin
            buf_push  = buf_pop | (BUFFER_WIDTH'(d_masked) << fill_pop);
            fill_push = fill_pop + SIZE_W'(bus.len);
        end

        case (state_q)
            ST_RUN: begin
                buffer_d = buf_push;
                fill_d   = fill_push;
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((fill_q == '0) || (pop && (fill_q <= WO_S))) begin
                    state_d  = ST_DONE;
                    buffer_d = '0;
                    fill_d   = '0;
                end else begin
                    buffer_d = buf_pop;
                    fill_d   = fill_pop;
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d  = ST_RUN;
                buffer_d = '0;
                fill_d   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_variable_length_encoder.sv
// tb/tb_variable_length_encoder.sv - bench for variable_length_encoder against a bit-queue model

module tb_variable_length_encoder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    variable_length_encoder_if #(.WIDTH_IN(8), .WIDTH_OUT(8), .BUFFER_WIDTH(16)) bus ();

    variable_length_encoder #(.WIDTH_IN(8), .WIDTH_OUT(8), .BUFFER_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: the stream as a queue of bits (front = oldest bit) plus a mode.
    localparam int M_RUN = 0, M_FLUSH = 1, M_DONE = 2;
    bit mbits[$];
    int mmode = M_RUN;

    function automatic int m_size();
        return mbits.size();
    endfunction

    function automatic logic [7:0] m_q();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) if (i < mbits.size()) r[i] = mbits[i];
        return r;
    endfunction

    function automatic bit m_valid();
        if (mmode == M_RUN)   return mbits.size() >= 8;
        if (mmode == M_FLUSH) return mbits.size() > 0;
        return 1'b0;
    endfunction

    function automatic bit m_full();
        return (mbits.size() > 8) || (mmode != M_RUN);
    endfunction

    always @(posedge clk) begin
        bit pop, acc;
        if (rst) begin
            mbits.delete();
            mmode = M_RUN;
        end else begin
            pop = m_valid() && bus.q_ready;
            acc = bus.push && !m_full();
            case (mmode)
                M_RUN: begin
                    if (pop) repeat (8) void'(mbits.pop_front());
                    if (acc) for (int b = 0; b < int'(bus.len); b++) mbits.push_back(bus.d[b]);
                    if (bus.flush) mmode = M_FLUSH;
                end
                M_FLUSH: begin
                    if (mbits.size() == 0 || (pop && mbits.size() <= 8)) begin
                        mbits.delete();
                        mmode = M_DONE;
                    end else if (pop) begin
                        repeat (8) void'(mbits.pop_front());
                    end
                end
                default: mmode = M_RUN;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("q",          32'(bus.q),          32'(m_q()));
            chk("q_valid",    32'(bus.q_valid),    32'(m_valid()));
            chk("full",       32'(bus.full),       32'(m_full()));
            chk("size",       32'(bus.size),       32'(m_size()));
            chk("flush_done", 32'(bus.flush_done), 32'(mmode == M_DONE));
        end
    end

    task automatic drive(input bit p, input logic [7:0] dv, input logic [3:0] lv, input bit fl, input bit rdy);
        bus.push    = p;
        bus.d       = dv;
        bus.len     = lv;
        bus.flush   = fl;
        bus.q_ready = rdy;
    endtask

    // Waits for the flush_done pulse, then one more cycle so the block is back in RUN.
    task automatic wait_done(input string name, input int maxc);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(negedge clk);
            if (bus.flush_done) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: flush_done not seen within %0d cycles", name, maxc);
        end
        drive(0, 8'h00, 4'd0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 8'hFF, 4'd8, 0, 0);
        @(posedge clk);
        chk_en = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_q",       32'(bus.q), 32'h0);
        chk("rst_q_valid", 32'(bus.q_valid), 32'h0);
        chk("rst_full",    32'(bus.full), 32'h0);
        chk("rst_size",    32'(bus.size), 32'h0);
        chk("rst_done",    32'(bus.flush_done), 32'h0);
        rst = 1'b0;
        drive(0, 8'h00, 4'd0, 0, 0);
        @(negedge clk);
        chk("post_rst_size", 32'(bus.size), 32'h0);

        // Packing with masking of unused d bits.
        drive(1, 8'h05, 4'd3, 0, 0);
        @(negedge clk);
        drive(1, 8'hFF, 4'd5, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        chk("pack_q",       32'(bus.q), 32'hFD);
        chk("pack_q_valid", 32'(bus.q_valid), 32'h1);
        chk("pack_size",    32'(bus.size), 32'd8);
        bus.q_ready = 1;
        @(negedge clk);
        bus.q_ready = 0;
        chk("pack_drained", 32'(bus.size), 32'd0);

        // Backpressure and full.
        drive(1, 8'hAA, 4'd8, 0, 0);
        @(negedge clk);
        drive(1, 8'h55, 4'd8, 0, 0);
        @(negedge clk);
        chk("bp_size16", 32'(bus.size), 32'd16);
        chk("bp_full",   32'(bus.full), 32'h1);
        drive(1, 8'h11, 4'd8, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        chk("bp_ignored", 32'(bus.size), 32'd16);
        @(negedge clk);
        chk("bp_hold_q", 32'(bus.q), 32'hAA);
        bus.q_ready = 1;
        @(negedge clk);
        chk("bp_q2",    32'(bus.q), 32'h55);
        chk("bp_size8", 32'(bus.size), 32'd8);
        @(negedge clk);
        chk("bp_empty_valid", 32'(bus.q_valid), 32'h0);
        chk("bp_empty_size",  32'(bus.size), 32'd0);
        bus.q_ready = 0;

        // Pop and push in one cycle at fill 8.
        drive(1, 8'hBC, 4'd8, 0, 0);
        @(negedge clk);
        drive(1, 8'h7F, 4'd7, 0, 1);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        chk("pp_size", 32'(bus.size), 32'd7);
        chk("pp_q",    32'(bus.q), 32'h7F);
        drive(0, 8'h00, 4'd0, 1, 1);
        @(negedge clk);
        bus.flush = 0;
        chk("pp_flush_q", 32'(bus.q), 32'h7F);
        wait_done("pp_flush", 6);

        // Fill 12: full, so a push alongside the pop is refused.
        drive(1, 8'hBC, 4'd8, 0, 0);
        @(negedge clk);
        drive(1, 8'h0A, 4'd4, 0, 0);
        @(negedge clk);
        chk("f12_size", 32'(bus.size), 32'd12);
        drive(1, 8'h7F, 4'd7, 0, 1);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        chk("f12_size_after", 32'(bus.size), 32'd4);
        chk("f12_q_after",    32'(bus.q), 32'h0A);
        drive(0, 8'h00, 4'd0, 1, 1);
        @(negedge clk);
        bus.flush = 0;
        wait_done("f12_flush", 6);

        // Flush of a 2-bit tail under backpressure.
        drive(1, 8'h03, 4'd2, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 1, 0);
        @(negedge clk);
        bus.flush = 0;
        chk("fl_q",       32'(bus.q), 32'h03);
        chk("fl_q_valid", 32'(bus.q_valid), 32'h1);
        chk("fl_full",    32'(bus.full), 32'h1);
        @(negedge clk);
        chk("fl_hold_q", 32'(bus.q), 32'h03);
        bus.q_ready = 1;
        @(negedge clk);
        bus.q_ready = 0;
        chk("fl_done",       32'(bus.flush_done), 32'h1);
        chk("fl_done_valid", 32'(bus.q_valid), 32'h0);
        @(negedge clk);
        chk("fl_done_pulse", 32'(bus.flush_done), 32'h0);
        chk("fl_run_size",   32'(bus.size), 32'd0);
        chk("fl_run_full",   32'(bus.full), 32'h0);

        // Empty flush: flush_done two cycles after the request.
        bus.flush = 1;
        @(negedge clk);
        bus.flush = 0;
        chk("ef_not_yet", 32'(bus.flush_done), 32'h0);
        @(negedge clk);
        chk("ef_done", 32'(bus.flush_done), 32'h1);
        @(negedge clk);

        // Reset in the middle of a flush.
        drive(1, 8'hBC, 4'd8, 0, 0);
        @(negedge clk);
        drive(1, 8'h0A, 4'd4, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 1, 0);
        @(negedge clk);
        bus.flush = 0;
        chk("rf_size12", 32'(bus.size), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rf_size",    32'(bus.size), 32'd0);
        chk("rf_valid",   32'(bus.q_valid), 32'h0);
        chk("rf_done",    32'(bus.flush_done), 32'h0);
        chk("rf_full",    32'(bus.full), 32'h0);
        repeat (3) @(negedge clk);

        // Mixed lengths, including 0 and 8, with intermittent backpressure.
        for (int i = 0; i < 40; i++) begin
            drive(1, 8'(i * 37 + 11), 4'(i % 9), 0, (i % 3) != 0);
            @(negedge clk);
        end
        drive(1, 8'h05, 4'd3, 1, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        repeat (2) @(negedge clk);
        bus.q_ready = 1;
        wait_done("mix_flush", 10);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
